// File: rtl/divu_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divu_pkg;

  localparam int DivuWidth    = 32;
  localparam int DivuCntWidth = $clog2(DivuWidth + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divuState_t;

  typedef struct packed {
    logic divByZero;
    logic overflow;
  } divuErr_t;

  // A zero divisor takes precedence; overflow means the quotient cannot fit in WIDTH bits.
  function automatic divuErr_t divuClassify(input logic divisorIsZero,
                                            input logic highGeDivisor);
    divuErr_t err;
    err.divByZero = divisorIsZero;
    err.overflow  = !divisorIsZero && highGeDivisor;
    return err;
  endfunction

endpackage

// File: rtl/divu_step.sv
// One combinational restoring-division step: shift {R,Q} left, trial-subtract, restore on borrow.
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rIn,
  input  logic [WIDTH-1:0] qIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rOut,
  output logic [WIDTH-1:0] qOut
);

  logic [WIDTH+1:0] rShift;
  logic [WIDTH+1:0] diff;
  logic             noBorrow;

  // The extra top bit of diff acts as the borrow flag of the trial subtraction.
  always_comb begin
    rShift   = {rIn, qIn[WIDTH-1]};
    diff     = rShift - {2'b00, divisor};
    noBorrow = ~diff[WIDTH+1];
    rOut     = noBorrow ? diff[WIDTH:0] : rShift[WIDTH:0];
    qOut     = {qIn[WIDTH-2:0], noBorrow};
  end

endmodule

// File: rtl/divu_seq.sv
// Sequential unsigned divider, one quotient bit per clock, level-held done.
// Optional macro DIVU_FAST_ERR_EN: error cases skip the iterations and finish at once.
module divu_seq
  import divu_pkg::*;
#(
  parameter int WIDTH = DivuWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_high,
  input  logic [WIDTH-1:0] dividend_low,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CntW = $clog2(WIDTH + 1);

  divuState_t       state;
  divuState_t       nextState;
  logic [WIDTH:0]   rReg;
  logic [WIDTH:0]   rStep;
  logic [WIDTH-1:0] qReg;
  logic [WIDTH-1:0] qStep;
  logic [WIDTH-1:0] divisorReg;
  logic [WIDTH-1:0] lowReg;
  logic [CntW-1:0]  cnt;
  divuErr_t         launchErr;
  logic             accept;
  logic             lastStep;

  assign launchErr = divuClassify(divisor == '0, dividend_high >= divisor);
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign lastStep  = (state == RUN) && (cnt == CntW'(1));

  divu_step #(.WIDTH(WIDTH)) uStep (
    .rIn    (rReg),
    .qIn    (qReg),
    .divisor(divisorReg),
    .rOut   (rStep),
    .qOut   (qStep)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
`ifdef DIVU_FAST_ERR_EN
          nextState = (launchErr.divByZero || launchErr.overflow) ? DONE : RUN;
`else
          nextState = RUN;
`endif
        end
      end
      RUN: begin
        if (cnt == CntW'(1)) nextState = DONE;
      end
      default: nextState = IDLE;
    endcase
  end

  // busy/done are registered copies of the next state so they line up with the result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      rReg        <= '0;
      qReg        <= '0;
      divisorReg  <= '0;
      lowReg      <= '0;
      cnt         <= '0;
    end else begin
      state <= nextState;
      busy  <= (nextState == RUN);
      done  <= (nextState == DONE);
      if (accept) begin
        rReg        <= {1'b0, dividend_high};
        qReg        <= dividend_low;
        divisorReg  <= divisor;
        lowReg      <= dividend_low;
        cnt         <= CntW'(WIDTH);
        div_by_zero <= launchErr.divByZero;
        overflow    <= launchErr.overflow;
`ifdef DIVU_FAST_ERR_EN
        if (launchErr.divByZero || launchErr.overflow) begin
          quotient  <= '1;
          remainder <= launchErr.divByZero ? dividend_low : '0;
          cnt       <= '0;
        end
`endif
      end else if (state == RUN) begin
        rReg <= rStep;
        qReg <= qStep;
        cnt  <= cnt - CntW'(1);
        // Error results override whatever the iterations produced.
        if (lastStep) begin
          if (div_by_zero) begin
            quotient  <= '1;
            remainder <= lowReg;
          end else if (overflow) begin
            quotient  <= '1;
            remainder <= '0;
          end else begin
            quotient  <= qStep;
            remainder <= rStep[WIDTH-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_divu_seq.sv
// Scoreboard bench for divu_seq: random and directed divides against an arithmetic reference model.
module tb_divu_seq;

  localparam int WIDTH = 32;
`ifdef DIVU_FAST_ERR_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    logic             ovf;
    int               doneEdge;
    int               busyCycles;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividendHigh;
  logic [WIDTH-1:0] dividendLow;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             divByZero;
  logic             overflow;

  int   checks = 0;
  int   errors = 0;
  int   edgeCnt = 0;
  exp_t sb[$];

  divu_seq #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .dividend_high(dividendHigh),
    .dividend_low (dividendLow),
    .divisor      (divisor),
    .busy         (busy),
    .done         (done),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (divByZero),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at edge %0d", edgeCnt);
    $fatal(1, "[TB] watchdog");
  end

  // Plain 2W-by-W arithmetic; latency follows from the accepting edge.
  function automatic exp_t refModel(input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo,
                                    input logic [WIDTH-1:0] dv, input int acceptEdge);
    exp_t        e;
    logic [63:0] dividend;
    bit          err;
    dividend = {hi, lo};
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (dv == 0) begin
      e.q   = '1;
      e.r   = lo;
      e.dbz = 1'b1;
    end else if (hi >= dv) begin
      e.q   = '1;
      e.r   = '0;
      e.ovf = 1'b1;
    end else begin
      e.q = WIDTH'(dividend / {32'd0, dv});
      e.r = WIDTH'(dividend % {32'd0, dv});
    end
    err          = e.dbz || e.ovf;
    e.doneEdge   = acceptEdge + ((Fast && err) ? 0 : WIDTH);
    e.busyCycles = (Fast && err) ? 0 : WIDTH;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (edge %0d)", name, actual, expected, edgeCnt);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo,
                               input logic [WIDTH-1:0] dv, input bit expectResult);
    dividendHigh = hi;
    dividendLow  = lo;
    divisor      = dv;
    start        = 1'b1;
    if (expectResult) sb.push_back(refModel(hi, lo, dv, edgeCnt + 1));
    @(negedge clk);
    start        = 1'b0;
    dividendHigh = $urandom;
    dividendLow  = $urandom;
    divisor      = $urandom;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("pendingAfterTimeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic waitDoneHigh();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneWithinBound", 64'(done), 64'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
    checkOutput({tag, ".done"}, 64'(done), 64'd0);
    checkOutput({tag, ".quotient"}, 64'(quotient), 64'd0);
    checkOutput({tag, ".remainder"}, 64'(remainder), 64'd0);
    checkOutput({tag, ".divByZero"}, 64'(divByZero), 64'd0);
    checkOutput({tag, ".overflow"}, 64'(overflow), 64'd0);
  endtask

  // Pops one expectation per rising done and compares results, latency and busy length.
  task automatic monitorLoop();
    logic prevDone = 1'b0;
    int   busyCount = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) busyCount++;
      if (done && !prevDone) begin
        if (sb.size() == 0) begin
          checkOutput("unexpectedDone", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("quotient", 64'(quotient), 64'(e.q));
          checkOutput("remainder", 64'(remainder), 64'(e.r));
          checkOutput("divByZero", 64'(divByZero), 64'(e.dbz));
          checkOutput("overflow", 64'(overflow), 64'(e.ovf));
          checkOutput("doneEdge", 64'(edgeCnt), 64'(e.doneEdge));
          checkOutput("busyCycles", 64'(busyCount), 64'(e.busyCycles));
        end
        busyCount = 0;
      end else if (!busy && !done) begin
        busyCount = 0;
      end
      prevDone = done;
    end
  endtask

  initial begin
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] dv;
    rst_n        = 1'b0;
    start        = 1'b1;
    dividendHigh = '0;
    dividendLow  = 32'd55;
    divisor      = 32'd3;
    fork
      monitorLoop();
    join_none
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed cases");
    applyStimulus(32'd0, 32'd100, 32'd7, 1'b1);
    waitIdle();
    applyStimulus(32'd1, 32'd0, 32'd3, 1'b1);
    waitIdle();
    applyStimulus(32'd0, 32'h1234, 32'd0, 1'b1);
    waitIdle();
    applyStimulus(32'd5, 32'd77, 32'd5, 1'b1);
    waitIdle();
    applyStimulus(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    waitIdle();

    $display("[TB] start ignored in RUN, then back-to-back start in DONE");
    applyStimulus(32'd0, 32'd100, 32'd7, 1'b1);
    repeat (5) @(negedge clk);
    applyStimulus(32'd0, 32'd9, 32'd2, 1'b0);
    waitDoneHigh();
    applyStimulus(32'd0, 32'd9, 32'd2, 1'b1);
    checkOutput("doneDropAfterRestart", 64'(done), 64'd0);
    waitIdle();

    $display("[TB] reset in the middle of an operation");
    applyStimulus(32'd0, 32'd100, 32'd7, 1'b1);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    checkAllZero("midReset");
    applyStimulus(32'd1, 32'd0, 32'd3, 1'b1);
    waitIdle();

    $display("[TB] random cases");
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 9))
        0: begin
          dv = '0;
          hi = $urandom;
        end
        1: begin
          dv = $urandom_range(1, 32'h7FFF_FFFF);
          hi = dv + 32'($urandom_range(0, 3));
        end
        default: begin
          dv = $urandom;
          if (dv == 0) dv = 32'd1;
          if (i % 3 == 0) dv = dv >> $urandom_range(0, 31);
          if (dv == 0) dv = 32'd1;
          hi = $urandom % dv;
        end
      endcase
      lo = $urandom;
      applyStimulus(hi, lo, dv, 1'b1);
      if (i % 2 == 0) begin
        waitDoneHigh();
      end else begin
        waitIdle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    waitIdle();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
